mem_port_arbiter: RTL and testbench

//  Shares one single-port unified memory between the IF stage (instruction fetch, read-only)
//  and the MEM stage (data load/store).
//  - Grants one requester at a time; drives the memory port.
//  - Returns read data with a done pulse; raises per-stage stall while a request is outstanding.
//  - Aborts hung accesses on timeout.
//  - Sits between the pipeline stage registers and the memory model / MEM-stage mux.

---
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 518 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between the IF fetch port and the MEM-stage load/store port.
// Build option ARB_FAIR_EN: alternate grants under contention instead of DM-first priority.
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              err,
  output logic              stall_if,
  output logic              stall_dm,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  // Handshake: a requester raises req and holds it (with stable addr/data) until its
  // valid/done pulse, dropping it in that pulse cycle; mem_ack is a one-cycle completion
  // strobe honoured only while a grant is active (mem_en=1).
  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_DM} state_t;

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             if_elig;
  logic             dm_elig;
  logic             pick_if;
  logic             pick_dm;
  logic             timeout_hit;
  logic             finish;

  // A port whose completion pulse is out this cycle cannot be re-granted immediately.
  assign if_elig = if_req & ~if_valid;
  assign dm_elig = dm_req & ~dm_done;

`ifdef ARB_FAIR_EN
  logic last_dm;
  assign pick_if = if_elig & (~dm_elig | last_dm);
`else
  assign pick_if = if_elig & ~dm_elig;
`endif
  assign pick_dm = dm_elig & ~pick_if;

  // cnt holds the number of grant cycles already spent without an ack.
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
  assign finish      = mem_ack | timeout_hit;

  assign stall_if = if_req & ~if_valid;
  assign stall_dm = dm_req & ~dm_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      if_rdata  <= '0;
      if_valid  <= 1'b0;
      dm_rdata  <= '0;
      dm_done   <= 1'b0;
      err       <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef ARB_FAIR_EN
      last_dm   <= 1'b0;
`endif
    end else begin
      if_valid <= 1'b0;
      dm_done  <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (pick_dm) begin
            state     <= GNT_DM;
            mem_en    <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
`ifdef ARB_FAIR_EN
            last_dm   <= 1'b1;
`endif
          end else if (pick_if) begin
            state     <= GNT_IF;
            mem_en    <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
`ifdef ARB_FAIR_EN
            last_dm   <= 1'b0;
`endif
          end
        end
        GNT_IF, GNT_DM: begin
          if (finish) begin
            state  <= IDLE;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            cnt    <= '0;
            err    <= ~mem_ack;
            if (state == GNT_IF) begin
              if_valid <= 1'b1;
              if_rdata <= mem_ack ? mem_rdata : '0;
            end else begin
              dm_done  <= 1'b1;
              dm_rdata <= (mem_ack & ~mem_we) ? mem_rdata : '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          mem_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized rounds
// scored against a transaction-level model of grant order, latency and returned data.
module tb_mem_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 15;
`ifdef ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [DW-1:0] dm_rdata;
  logic          dm_done;
  logic          err;
  logic          stall_if;
  logic          stall_dm;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stall_bad = 0;
  bit m_last_dm = 1'b0;

  // completion record {dm_port, err, rdata, cycle}; grant record {we, addr, wdata}
  logic [49:0] exp_q[$];
  logic [49:0] obs_q[$];
  logic [48:0] exp_g[$];
  logic [48:0] gnt_q[$];
  int          delay_q[$];
  logic [31:0] mem_model[logic [15:0]];
  logic [31:0] exp_mem[logic [15:0]];

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .err(err),
    .stall_if(stall_if), .stall_dm(stall_dm),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic logic [31:0] init_word(input logic [15:0] a);
    return {a ^ 16'hA5C3, ~a};
  endfunction

  function automatic logic [31:0] exp_rd(input logic [15:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : init_word(a);
  endfunction

  // Memory model: acks each grant after the next queued number of wait cycles.
  int g_cnt = 0;
  int cur_d = 0;
  always @(negedge clk) begin
    if (mem_en === 1'b1) begin
      if (g_cnt == 0) begin
        cur_d = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
        gnt_q.push_back({mem_we, mem_addr, mem_wdata});
      end
      g_cnt++;
      if (g_cnt == cur_d + 1) begin
        mem_ack = 1'b1;
        if (mem_we) begin
          mem_model[mem_addr] = mem_wdata;
          mem_rdata = $urandom;
        end else begin
          mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : init_word(mem_addr);
        end
      end else begin
        mem_ack = 1'b0;
        mem_rdata = $urandom;
      end
    end else begin
      g_cnt = 0;
      mem_ack = 1'b0;
      mem_rdata = $urandom;
    end
  end

  // Collector: completions and stall consistency, sampled mid-cycle.
  always @(negedge clk) begin
    if (if_valid === 1'b1) obs_q.push_back({1'b0, err, if_rdata, cyc[15:0]});
    if (dm_done === 1'b1) obs_q.push_back({1'b1, err, dm_rdata, cyc[15:0]});
    if (!reset && (stall_if !== (if_req & ~if_valid) || stall_dm !== (dm_req & ~dm_done)))
      stall_bad++;
  end

  // ---------------- driver tasks ----------------
  task automatic align;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    align();
    reset = 1'b1;
    if_req = 1'b0;
    dm_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete(); obs_q.delete(); exp_g.delete(); gnt_q.delete(); delay_q.delete();
    m_last_dm = 1'b0;
  endtask

  task automatic drive_if(input logic [15:0] a);
    int n;
    if_addr = a;
    if_req = 1'b1;
    n = 0;
    @(negedge clk);
    while (if_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (if_valid !== 1'b1) begin
      errors++;
      $display("FAIL if_handshake: if_valid=%b after %0d cycles, required 1", if_valid, n);
    end
    #1 if_req = 1'b0;
  endtask

  task automatic drive_dm(input logic we, input logic [15:0] a, input logic [31:0] wd);
    int n;
    dm_we = we;
    dm_addr = a;
    dm_wdata = wd;
    dm_req = 1'b1;
    n = 0;
    @(negedge clk);
    while (dm_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (dm_done !== 1'b1) begin
      errors++;
      $display("FAIL dm_handshake: dm_done=%b after %0d cycles, required 1", dm_done, n);
    end
    #1 dm_req = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    logic [144:0] outs;
    reset = 1'b1;
    if_req = 1'b1;
    dm_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      outs = {if_rdata, dm_rdata, mem_addr, mem_wdata, if_valid, dm_done, err, mem_en, mem_we};
      checks++;
      if (outs !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got %h, required 0", outs);
      end
      checks++;
      if ({stall_if, stall_dm} !== 2'b11) begin
        errors++;
        $display("FAIL reset_stall: got %b, required 11 (req held)", {stall_if, stall_dm});
      end
    end
    #1 if_req = 1'b0;
    dm_req = 1'b0;
    align();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_en, if_valid, dm_done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_release: mem_en/if_valid/dm_done=%b, required 000", {mem_en, if_valid, dm_done});
    end
  endtask

  task automatic test_if_zero_wait;
    mem_model[16'h0040] = 32'hDEADBEEF;
    align();
    delay_q.push_back(0);
    if_addr = 16'h0040;
    if_req = 1'b1;
    @(negedge clk);
    checks++;
    if ({stall_if, mem_en} !== 2'b10) begin
      errors++;
      $display("FAIL if_c0: stall_if/mem_en=%b, required 10", {stall_if, mem_en});
    end
    @(negedge clk);
    checks++;
    if ({stall_if, mem_en, mem_we, if_valid, mem_addr} !== {4'b1100, 16'h0040}) begin
      errors++;
      $display("FAIL if_c1: stall/en/we/valid=%b addr=%h, required 1100 0040",
               {stall_if, mem_en, mem_we, if_valid}, mem_addr);
    end
    @(negedge clk);
    checks++;
    if ({if_valid, err, stall_if, mem_en} !== 4'b1000 || if_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL if_c2: valid/err/stall/en=%b rdata=%h, required 1000 deadbeef",
               {if_valid, err, stall_if, mem_en}, if_rdata);
    end
    #1 if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (if_valid !== 1'b0) begin
      errors++;
      $display("FAIL if_pulse: if_valid=%b in c3, required 0", if_valid);
    end
  endtask

  task automatic test_contention;
    int c0;
    logic [49:0] e0, e1;
    align();
    c0 = cyc;
    obs_q.delete();
    gnt_q.delete();
    delay_q.push_back(0);
    delay_q.push_back(0);
    fork
      drive_dm(1'b1, 16'h0100, 32'h12345678);
      drive_if(16'h0200);
    join
    repeat (2) @(posedge clk);
    e0 = {1'b1, 1'b0, 32'h0, 16'(c0 + 2)};
    e1 = {1'b0, 1'b0, init_word(16'h0200), 16'(c0 + 4)};
    checks++;
    if (gnt_q.size() != 2 || obs_q.size() != 2) begin
      errors++;
      $display("FAIL contention_count: grants=%0d completions=%0d, required 2 2", gnt_q.size(), obs_q.size());
    end else begin
      checks++;
      if (gnt_q[0] !== {1'b1, 16'h0100, 32'h12345678} || gnt_q[1] !== {1'b0, 16'h0200, 32'h0}) begin
        errors++;
        $display("FAIL contention_grants: got %h %h, required dm store then if read", gnt_q[0], gnt_q[1]);
      end
      checks++;
      if (obs_q[0] !== e0 || obs_q[1] !== e1) begin
        errors++;
        $display("FAIL contention_done: got %h %h, required %h %h", obs_q[0], obs_q[1], e0, e1);
      end
    end
  endtask

  task automatic test_ack_at_timeout;
    int c0;
    logic [49:0] e;
    align();
    c0 = cyc;
    obs_q.delete();
    delay_q.push_back(TO - 1);
    drive_dm(1'b0, 16'h0301, 32'h0);
    repeat (2) @(posedge clk);
    e = {1'b1, 1'b0, init_word(16'h0301), 16'(c0 + TO + 1)};
    checks++;
    if (obs_q.size() != 1) begin
      errors++;
      $display("FAIL ack_timeout_count: completions=%0d, required 1", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0] !== e) begin
        errors++;
        $display("FAIL ack_timeout_same_cycle: got %h, required %h", obs_q[0], e);
      end
    end
  endtask

  task automatic test_timeout;
    int c0, en_cnt, n;
    align();
    c0 = cyc;
    delay_q.push_back(99);
    dm_we = 1'b0;
    dm_addr = 16'h0300;
    dm_req = 1'b1;
    en_cnt = 0;
    n = 0;
    forever begin
      @(negedge clk);
      if (mem_en === 1'b1) en_cnt++;
      if (dm_done === 1'b1 || n > 100) break;
      n++;
    end
    checks++;
    if ({dm_done, err} !== 2'b11 || dm_rdata !== 32'h0 || cyc != c0 + TO + 1) begin
      errors++;
      $display("FAIL timeout_done: done/err=%b rdata=%h cycle=%0d, required 11 0 %0d",
               {dm_done, err}, dm_rdata, cyc - c0, TO + 1);
    end
    checks++;
    if (en_cnt != TO) begin
      errors++;
      $display("FAIL timeout_en_cycles: mem_en high %0d cycles, required %0d", en_cnt, TO);
    end
    #1 dm_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_en, dm_done, err} !== 3'b000) begin
      errors++;
      $display("FAIL timeout_idle: en/done/err=%b, required 000", {mem_en, dm_done, err});
    end
  endtask

  task automatic test_reset_mid_access;
    int bad;
    align();
    delay_q.push_back(99);
    if_addr = 16'h0400;
    if_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_grant: mem_en=%b, required 1 before reset", mem_en);
    end
    #1 reset = 1'b1;
    if_req = 1'b0;
    align();
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ({if_valid, mem_en, err} !== 3'b000) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_mid_drop: %0d cycles with valid/en/err set, required 0", bad);
    end
    delay_q.delete();
  endtask

  task automatic test_fair;
    logic [48:0] exp_list[$];
    bit p;
    int di, ii;
    logic [15:0] dm_a[4];
    logic [15:0] if_a[4];
    do_reset();
    dm_a = '{16'h2000, 16'h2001, 16'h2002, 16'h2003};
    if_a = '{16'h1000, 16'h1001, 16'h1002, 16'h1003};
    // both held for four accesses: the finisher is never eligible, so the other wins
    p = !(FAIR && m_last_dm);
    di = 0;
    ii = 0;
    for (int k = 0; k < 4; k++) begin
      if (p) begin exp_list.push_back({1'b1, dm_a[di], 32'hC0DE0000 + 32'(di)}); di++; end
      else begin exp_list.push_back({1'b0, if_a[ii], 32'h0}); ii++; end
      m_last_dm = p;
      p = ~p;
      delay_q.push_back(0);
    end
    align();
    fork
      begin
        drive_dm(1'b1, dm_a[0], 32'hC0DE0000);
        align();
        drive_dm(1'b1, dm_a[1], 32'hC0DE0001);
      end
      begin
        drive_if(if_a[0]);
        align();
        drive_if(if_a[1]);
      end
    join
    // lone DM access, then a fresh simultaneous request from both ports
    exp_list.push_back({1'b1, dm_a[2], 32'hC0DE0002});
    m_last_dm = 1'b1;
    p = !(FAIR && m_last_dm);
    exp_list.push_back(p ? {1'b1, dm_a[3], 32'hC0DE0003} : {1'b0, if_a[2], 32'h0});
    exp_list.push_back(p ? {1'b0, if_a[2], 32'h0} : {1'b1, dm_a[3], 32'hC0DE0003});
    repeat (3) delay_q.push_back(0);
    align();
    drive_dm(1'b1, dm_a[2], 32'hC0DE0002);
    align();
    fork
      drive_dm(1'b1, dm_a[3], 32'hC0DE0003);
      drive_if(if_a[2]);
    join
    repeat (2) @(posedge clk);
    checks++;
    if (gnt_q.size() != exp_list.size()) begin
      errors++;
      $display("FAIL fair_count: grants=%0d, required %0d", gnt_q.size(), exp_list.size());
    end
    for (int k = 0; k < exp_list.size() && k < gnt_q.size(); k++) begin
      checks++;
      if (gnt_q[k] !== exp_list[k]) begin
        errors++;
        $display("FAIL fair_order[%0d]: got %h, required %h", k, gnt_q[k], exp_list[k]);
      end
    end
  endtask

  task automatic test_random;
    int c0, prev_done, d, g, done, kind;
    int d_if, d_dm;
    bit has_if, has_dm, first_dm, p, e, we;
    logic [15:0] iadr, dadr, a;
    logic [31:0] dwd, wd, data;
    logic dwe;
    logic [49:0] eo, oo;
    logic [48:0] eg, og;
    do_reset();
    for (int r = 0; r < 40; r++) begin
      kind = $urandom_range(0, 2);
      has_if = (kind != 1);
      has_dm = (kind != 0);
      iadr = 16'h0010 + 16'($urandom_range(0, 7));
      dadr = 16'h0010 + 16'($urandom_range(0, 7));
      dwe = 1'($urandom_range(0, 1));
      dwd = $urandom;
      d_if = $urandom_range(0, 9);
      d_if = (d_if < 6) ? $urandom_range(0, 3) : (d_if < 8) ? TO - 1 : 99;
      d_dm = $urandom_range(0, 9);
      d_dm = (d_dm < 6) ? $urandom_range(0, 3) : (d_dm < 8) ? TO - 1 : 99;
      align();
      c0 = cyc;
      first_dm = has_dm && !(has_if && FAIR && m_last_dm);
      prev_done = -1;
      for (int k = 0; k < 2; k++) begin
        p = (k == 0) ? first_dm : ~first_dm;
        if ((p && !has_dm) || (!p && !has_if)) continue;
        d = p ? d_dm : d_if;
        g = (d < TO) ? d + 1 : TO;
        e = (d >= TO);
        done = ((prev_done < 0) ? c0 + 1 : prev_done + 1) + g;
        prev_done = done;
        we = p ? dwe : 1'b0;
        a = p ? dadr : iadr;
        wd = p ? dwd : 32'h0;
        data = (e || we) ? 32'h0 : exp_rd(a);
        if (!e && we) exp_mem[a] = wd;
        exp_g.push_back({we, a, wd});
        exp_q.push_back({p, e, data, 16'(done)});
        delay_q.push_back(d);
        m_last_dm = p;
      end
      fork
        if (has_if) drive_if(iadr);
        if (has_dm) drive_dm(dwe, dadr, dwd);
      join
      repeat (2) @(posedge clk);
      checks++;
      if (obs_q.size() != exp_q.size() || gnt_q.size() != exp_g.size()) begin
        errors++;
        $display("FAIL rand_count[%0d]: completions=%0d grants=%0d, required %0d %0d",
                 r, obs_q.size(), gnt_q.size(), exp_q.size(), exp_g.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        eo = exp_q.pop_front();
        oo = obs_q.pop_front();
        checks++;
        if (oo !== eo) begin
          errors++;
          $display("FAIL rand_done[%0d]: got %h, required %h", r, oo, eo);
        end
      end
      while (exp_g.size() > 0 && gnt_q.size() > 0) begin
        eg = exp_g.pop_front();
        og = gnt_q.pop_front();
        checks++;
        if (og !== eg) begin
          errors++;
          $display("FAIL rand_grant[%0d]: got %h, required %h", r, og, eg);
        end
      end
      exp_q.delete(); obs_q.delete(); exp_g.delete(); gnt_q.delete(); delay_q.delete();
    end
    checks++;
    if (stall_bad != 0) begin
      errors++;
      $display("FAIL stall_formula: %0d cycles inconsistent, required 0", stall_bad);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_if_zero_wait();
    test_contention();
    test_ack_at_timeout();
    test_timeout();
    test_reset_mid_access();
    test_fair();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
